// File: rtl/sign_correlator_if.sv
// Sample/result bundle for sign_correlator.
// The master drives the sample stream and threshold; the slave (the correlator)
// drives the correlation results, metric, detection flag and output strobe.
interface sign_correlator_if #(
    parameter int DW  = 16,
    parameter int LEN = 16
);
    localparam int L  = $clog2(LEN);
    localparam int OW = DW + 1 + L;

    logic                 inEn;
    logic signed [DW-1:0] in_Real;
    logic signed [DW-1:0] in_Imag;
    logic        [OW:0]   threshold;
    logic signed [OW-1:0] output_Real;
    logic signed [OW-1:0] output_Imag;
    logic        [OW:0]   metric;
    logic                 det_flag;
    logic                 OutputEnable;

    modport master (
        output inEn, in_Real, in_Imag, threshold,
        input  output_Real, output_Imag, metric, det_flag, OutputEnable
    );

    modport slave (
        input  inEn, in_Real, in_Imag, threshold,
        output output_Real, output_Imag, metric, det_flag, OutputEnable
    );
endinterface

// File: rtl/sign_correlator.sv
// Sliding-window complex correlator against a +-1+-j quantised reference.
// Delay line -> per-tap add/sub -> L-stage registered adder tree -> metric ->
// output alignment. Latency from sample acceptance is L+3 edges.
// Define SIGN_CORR_METRIC_EN to build the |re|+|im| metric and threshold
// detector; without it metric/det_flag are tied to 0 and threshold is ignored,
// while the complex outputs keep the same latency.
// The interface instance must use the same DW and LEN as this module.
module sign_correlator #(
    parameter int             DW      = 16,
    parameter int             LEN     = 16,
    parameter logic [LEN-1:0] COEF_RE = '0,
    parameter logic [LEN-1:0] COEF_IM = '0
) (
    input logic              Clk,
    input logic              Rst,
    sign_correlator_if.slave bus
);
    localparam int L  = $clog2(LEN);
    localparam int OW = DW + 1 + L;
    localparam int PW = DW + 1;

    localparam logic [L:0] FILL_FULL = (L+1)'(LEN);
    localparam logic [L:0] FILL_LAST = (L+1)'(LEN - 1);

    // x * conj(c) for c = (+-1) + j(+-1); neg_re/neg_im set means that part of c is -1
    function automatic logic signed [PW-1:0] tap_re(input logic signed [DW-1:0] a_in,
                                                    input logic signed [DW-1:0] b_in,
                                                    input logic neg_re, input logic neg_im);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = {a_in[DW-1], a_in};
        b = {b_in[DW-1], b_in};
        case ({neg_re, neg_im})
            2'b00:   return a + b;
            2'b10:   return b - a;
            2'b01:   return a - b;
            default: return -a - b;
        endcase
    endfunction

    function automatic logic signed [PW-1:0] tap_im(input logic signed [DW-1:0] a_in,
                                                    input logic signed [DW-1:0] b_in,
                                                    input logic neg_re, input logic neg_im);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = {a_in[DW-1], a_in};
        b = {b_in[DW-1], b_in};
        case ({neg_re, neg_im})
            2'b00:   return b - a;
            2'b10:   return -b - a;
            2'b01:   return b + a;
            default: return a - b;
        endcase
    endfunction

    logic signed [DW-1:0] dl_re [LEN];
    logic signed [DW-1:0] dl_im [LEN];
    logic [L:0]           fill_cnt;
    logic                 v_dl;

    logic signed [PW-1:0] prod_re [LEN];
    logic signed [PW-1:0] prod_im [LEN];
    logic                 v_prod;

    logic [L-1:0]         v_tree;

    logic signed [OW-1:0] m_re;
    logic signed [OW-1:0] m_im;
    logic                 v_m;

    // Delay line shifts on each accepted sample; tag marks a full window including this sample
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < LEN; k++) begin
                dl_re[k] <= '0;
                dl_im[k] <= '0;
            end
            fill_cnt <= '0;
            v_dl     <= 1'b0;
        end else begin
            v_dl <= bus.inEn && (fill_cnt >= FILL_LAST);
            if (bus.inEn) begin
                dl_re[0] <= bus.in_Real;
                dl_im[0] <= bus.in_Imag;
                for (int k = 1; k < LEN; k++) begin
                    dl_re[k] <= dl_re[k-1];
                    dl_im[k] <= dl_im[k-1];
                end
                if (fill_cnt != FILL_FULL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    // Per-tap products; bit 0 of COEF_* belongs to the oldest tap
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < LEN; k++) begin
                prod_re[k] <= '0;
                prod_im[k] <= '0;
            end
            v_prod <= 1'b0;
        end else begin
            for (int k = 0; k < LEN; k++) begin
                prod_re[k] <= tap_re(dl_re[k], dl_im[k], COEF_RE[LEN-1-k], COEF_IM[LEN-1-k]);
                prod_im[k] <= tap_im(dl_re[k], dl_im[k], COEF_RE[LEN-1-k], COEF_IM[LEN-1-k]);
            end
            v_prod <= v_dl;
        end
    end

    // Binary adder tree, one register level per stage, growing one bit per stage
    for (genvar s = 0; s < L; s++) begin : g_lvl
        localparam int WI = PW + s;
        localparam int WO = WI + 1;
        localparam int N  = LEN >> (s + 1);

        logic signed [WI-1:0] src_re [2*N];
        logic signed [WI-1:0] src_im [2*N];
        logic signed [WO-1:0] sum_re [N];
        logic signed [WO-1:0] sum_im [N];

        for (genvar i = 0; i < 2*N; i++) begin : g_src
            if (s == 0) begin : g_first
                assign src_re[i] = prod_re[i];
                assign src_im[i] = prod_im[i];
            end else begin : g_next
                assign src_re[i] = g_lvl[s-1].sum_re[i];
                assign src_im[i] = g_lvl[s-1].sum_im[i];
            end
        end

        // Pairwise sums of the previous level
        always_ff @(posedge Clk) begin
            if (Rst) begin
                for (int i = 0; i < N; i++) begin
                    sum_re[i] <= '0;
                    sum_im[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    sum_re[i] <= {src_re[2*i][WI-1], src_re[2*i]} + {src_re[2*i+1][WI-1], src_re[2*i+1]};
                    sum_im[i] <= {src_im[2*i][WI-1], src_im[2*i]} + {src_im[2*i+1][WI-1], src_im[2*i+1]};
                end
            end
        end
    end

    // Valid tag rides alongside the tree levels
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v_tree <= '0;
        end else begin
            v_tree[0] <= v_prod;
            for (int s = 1; s < L; s++) begin
                v_tree[s] <= v_tree[s-1];
            end
        end
    end

`ifdef SIGN_CORR_METRIC_EN
    logic [OW:0] m_mag;

    // |x| widened by one bit so the most negative value is representable
    function automatic logic [OW:0] mag(input logic signed [OW-1:0] x);
        logic [OW:0] xe;
        xe = {x[OW-1], x};
        return xe[OW] ? (~xe + 1'b1) : xe;
    endfunction
`endif

    // Metric stage; complex results are held here so they line up with the metric
    always_ff @(posedge Clk) begin
        if (Rst) begin
            m_re  <= '0;
            m_im  <= '0;
            v_m   <= 1'b0;
`ifdef SIGN_CORR_METRIC_EN
            m_mag <= '0;
`endif
        end else begin
            m_re  <= g_lvl[L-1].sum_re[0];
            m_im  <= g_lvl[L-1].sum_im[0];
            v_m   <= v_tree[L-1];
`ifdef SIGN_CORR_METRIC_EN
            m_mag <= mag(g_lvl[L-1].sum_re[0]) + mag(g_lvl[L-1].sum_im[0]);
`endif
        end
    end

    // Output alignment register; everything is forced to zero when not valid
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.OutputEnable <= 1'b0;
            bus.output_Real  <= '0;
            bus.output_Imag  <= '0;
`ifdef SIGN_CORR_METRIC_EN
            bus.metric       <= '0;
            bus.det_flag     <= 1'b0;
`endif
        end else begin
            bus.OutputEnable <= v_m;
            bus.output_Real  <= v_m ? m_re : '0;
            bus.output_Imag  <= v_m ? m_im : '0;
`ifdef SIGN_CORR_METRIC_EN
            bus.metric       <= v_m ? m_mag : '0;
            bus.det_flag     <= v_m && (m_mag >= bus.threshold);
`endif
        end
    end

`ifndef SIGN_CORR_METRIC_EN
    logic unused_thr;

    assign unused_thr   = ^bus.threshold;
    assign bus.metric   = '0;
    assign bus.det_flag = 1'b0;
`endif

endmodule
